cache_ctrl: RTL and testbench

// Controller end of the L1 storage array interface: accepts trace commands (command_t),

---
 rtl/cache_ctrl.sv | 270 +++++++++++++++++++++++++++
 tb/tb_cache_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cache_ctrl (+ cache_ctrl_pkg)
// Desc     : L1 controller: tag match, LRU victim, MESI update, set write-back.
//            Macro CACHE_CTRL_STATS_EN adds saturating access counters.
// Revision : 1.0  initial release
// ============================================================================
package cache_ctrl_pkg;
  localparam int c_sets   = 16384;
  localparam int c_ways   = 8;
  localparam int c_set_w  = $clog2(c_sets);
  localparam int c_lru_w  = $clog2(c_ways);
  localparam int c_tag_w  = 12;
  localparam int c_ofs_w  = 6;
  localparam int c_data_w = 32;

  typedef struct packed {
    logic [c_tag_w-1:0] tag;
    logic [c_set_w-1:0] set_index;
    logic [c_ofs_w-1:0] offset;
  } address_t;

  typedef struct packed {
    logic [3:0] n;
    address_t   address;
  } command_t;

  typedef struct packed {
    logic [1:0]          mesi;
    logic [c_tag_w-1:0]  tag;
    logic [c_lru_w-1:0]  lru;
    logic [c_data_w-1:0] data;
  } cache_line_t;

  localparam logic [1:0] c_mesi_i = 2'd0;
  localparam logic [1:0] c_mesi_s = 2'd1;
  localparam logic [1:0] c_mesi_e = 2'd2;
  localparam logic [1:0] c_mesi_m = 2'd3;

  localparam logic [2:0] c_bus_none  = 3'd0;
  localparam logic [2:0] c_bus_read  = 3'd1;
  localparam logic [2:0] c_bus_write = 3'd2;
  localparam logic [2:0] c_bus_rwim  = 3'd3;
  localparam logic [2:0] c_bus_inval = 3'd4;

  localparam logic [1:0] c_rsp_nohit = 2'd0;
  localparam logic [1:0] c_rsp_hit   = 2'd1;
  localparam logic [1:0] c_rsp_hitm  = 2'd2;
endpackage

module cache_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int SETS = c_sets,
  parameter int WAYS = c_ways
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  command_t                 cmd_in,
  input  logic [1:0]               snoop_in,
  output command_t                 store_cmd,
  input  cache_line_t [WAYS-1:0]   cache_rd,
  output cache_line_t [WAYS-1:0]   cache_wr,
  output logic [2:0]               bus_op,
  output logic [1:0]               snoop_rsp,
  output logic                     done,
  output logic                     hit
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [31:0]              stat_reads,
  output logic [31:0]              stat_writes,
  output logic [31:0]              stat_hits,
  output logic [31:0]              stat_misses
`endif
);

  typedef cache_line_t [WAYS-1:0] set_t;

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_lookup = 2'd1;
  localparam logic [1:0] c_st_update = 2'd2;
  localparam logic [1:0] c_st_write  = 2'd3;

  // The line struct is sized from the package, so the instance must agree with it.
  if (SETS != c_sets || WAYS != c_ways) begin : g_cfg_check
    $error("cache_ctrl: SETS/WAYS must match cache_ctrl_pkg");
  end

  logic [1:0]         r_state;
  command_t           r_cmd;
  set_t               r_set;
  set_t               r_wr_set;
  logic [2:0]         r_bus_op;
  logic [1:0]         r_snoop_rsp;
  logic               r_hit;

  logic               w_storage_op;
  logic               w_hit;
  logic [c_lru_w-1:0] w_hit_way;
  logic               w_have_inv;
  logic [c_lru_w-1:0] w_inv_way;
  logic [c_lru_w-1:0] w_lru_way;
  logic [c_lru_w-1:0] w_victim;
  logic               w_evict;
  logic               w_hit_rpt;
  logic [2:0]         w_bus_final;
  logic [1:0]         w_snoop;
  set_t               w_fill;
  set_t               w_mod;
  set_t               w_new_set;

  function automatic set_t f_touch(input set_t s, input logic [c_lru_w-1:0] t);
    set_t r;
    r = s;
    for (int w = 0; w < WAYS; w++) begin
      if (c_lru_w'(w) == t)
        r[w].lru = '0;
      else if (s[w].lru < s[t].lru)
        r[w].lru = s[w].lru + 1'b1;
    end
    return r;
  endfunction

  assign w_storage_op = r_cmd.n inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9};

  // Descending scans so the lowest matching index is the one kept.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_way  = '0;
    w_have_inv = 1'b0;
    w_inv_way  = '0;
    w_lru_way  = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_set[w].mesi != c_mesi_i && r_set[w].tag == r_cmd.address.tag) begin
        w_hit     = 1'b1;
        w_hit_way = c_lru_w'(w);
      end
      if (r_set[w].mesi == c_mesi_i) begin
        w_have_inv = 1'b1;
        w_inv_way  = c_lru_w'(w);
      end
      if (r_set[w].lru == c_lru_w'(WAYS - 1))
        w_lru_way = c_lru_w'(w);
    end
    w_victim = w_have_inv ? w_inv_way : w_lru_way;
  end

  always_comb begin
    w_fill = r_set;
    w_fill[w_victim].tag  = r_cmd.address.tag;
    w_fill[w_victim].mesi = (r_cmd.n == 4'd1) ? c_mesi_m :
                            (snoop_in != 2'd0) ? c_mesi_s : c_mesi_e;
    w_mod       = r_set;
    w_new_set   = r_set;
    w_bus_final = c_bus_none;
    w_snoop     = c_rsp_nohit;
    w_evict     = 1'b0;
    w_hit_rpt   = w_hit;
    case (r_cmd.n)
      4'd0, 4'd1, 4'd2: begin
        if (w_hit) begin
          if (r_cmd.n == 4'd1) begin
            if (r_set[w_hit_way].mesi == c_mesi_s)
              w_bus_final = c_bus_inval;
            w_mod[w_hit_way].mesi = c_mesi_m;
          end
          w_new_set = f_touch(w_mod, w_hit_way);
        end else begin
          w_evict     = (r_set[w_victim].mesi == c_mesi_m);
          w_bus_final = (r_cmd.n == 4'd1) ? c_bus_rwim : c_bus_read;
          w_new_set   = f_touch(w_fill, w_victim);
        end
      end
      4'd3: begin
        if (w_hit) begin
          if (r_set[w_hit_way].mesi == c_mesi_m) begin
            w_snoop     = c_rsp_hitm;
            w_bus_final = c_bus_write;
          end else begin
            w_snoop     = c_rsp_hit;
          end
          w_mod[w_hit_way].mesi = c_mesi_s;
          w_new_set = w_mod;
        end
      end
      4'd4: begin
      end
      4'd8, 4'd9: w_hit_rpt = 1'b0;
      default:    w_hit_rpt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= c_st_idle;
      r_cmd       <= '0;
      r_set       <= '0;
      r_wr_set    <= '0;
      r_bus_op    <= c_bus_none;
      r_snoop_rsp <= c_rsp_nohit;
      r_hit       <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (cmd_valid) begin
            r_cmd   <= cmd_in;
            r_state <= c_st_lookup;
          end
        end
        c_st_lookup: begin
          r_set   <= cache_rd;
          r_state <= c_st_update;
        end
        c_st_update: begin
          r_wr_set    <= w_new_set;
          r_bus_op    <= w_bus_final;
          r_snoop_rsp <= w_snoop;
          r_hit       <= w_hit_rpt;
          r_state     <= c_st_write;
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  always_comb begin
    store_cmd   = '0;
    store_cmd.n = 4'hf;
    if (r_state != c_st_idle && w_storage_op)
      store_cmd = r_cmd;
  end

  assign cmd_ready = (r_state == c_st_idle);
  assign done      = (r_state == c_st_write);
  assign hit       = done & r_hit;
  assign snoop_rsp = done ? r_snoop_rsp : c_rsp_nohit;
  assign cache_wr  = done ? r_wr_set : '0;
  // Dirty-victim write-back goes out a cycle ahead of the fill request.
  assign bus_op    = (r_state == c_st_update && w_evict) ? c_bus_write :
                     done ? r_bus_op : c_bus_none;

`ifdef CACHE_CTRL_STATS_EN
  logic w_count;
  assign w_count = done && (r_cmd.n <= 4'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_reads  <= '0;
      stat_writes <= '0;
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (w_count) begin
      if (r_cmd.n == 4'd1) begin
        if (stat_writes != '1) stat_writes <= stat_writes + 1'b1;
      end else begin
        if (stat_reads != '1) stat_reads <= stat_reads + 1'b1;
      end
      if (r_hit) begin
        if (stat_hits != '1) stat_hits <= stat_hits + 1'b1;
      end else begin
        if (stat_misses != '1) stat_misses <= stat_misses + 1'b1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_ctrl
// Desc     : Scoreboard bench for cache_ctrl with a small storage-array model.
// Revision : 1.0  initial release
// ============================================================================
module tb_cache_ctrl;
  import cache_ctrl_pkg::*;

  typedef cache_line_t [7:0] set_t;

  typedef struct {
    set_t       set;
    logic       hit;
    logic [2:0] upd_op;
    logic [2:0] wr_op;
    logic [1:0] rsp;
    bit         chk_set;
    bit         noop;
    command_t   store;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  command_t    cmd_in = '0;
  logic [1:0]  snoop_in = 2'd0;
  command_t    store_cmd;
  set_t        cache_rd;
  set_t        cache_wr;
  logic [2:0]  bus_op;
  logic [1:0]  snoop_rsp;
  logic        done;
  logic        hit;
`ifdef CACHE_CTRL_STATS_EN
  logic [31:0] stat_reads, stat_writes, stat_hits, stat_misses;
`endif

  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  set_t mem [16];
  set_t ref_mem [16];

  always #5 clk = ~clk;

  assign cache_rd = mem[store_cmd.address.set_index[3:0]];

  cache_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_in(cmd_in), .snoop_in(snoop_in), .store_cmd(store_cmd),
    .cache_rd(cache_rd), .cache_wr(cache_wr), .bus_op(bus_op),
    .snoop_rsp(snoop_rsp), .done(done), .hit(hit)
`ifdef CACHE_CTRL_STATS_EN
    , .stat_reads(stat_reads), .stat_writes(stat_writes),
    .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
  );

  function automatic set_t touch(input set_t s, input int t);
    set_t r;
    r = s;
    for (int w = 0; w < 8; w++) begin
      if (w == t) r[w].lru = '0;
      else if (s[w].lru < s[t].lru) r[w].lru = s[w].lru + 3'd1;
    end
    return r;
  endfunction

  function automatic exp_t model(input command_t c, input logic [1:0] sn, input set_t s);
    exp_t e;
    int hw;
    int vw;
    e.set = s; e.hit = 1'b0; e.upd_op = c_bus_none; e.wr_op = c_bus_none;
    e.rsp = c_rsp_nohit; e.chk_set = 1'b1; e.noop = 1'b0; e.store = c;
    hw = -1;
    vw = -1;
    for (int w = 0; w < 8; w++)
      if (hw < 0 && s[w].mesi != c_mesi_i && s[w].tag == c.address.tag) hw = w;
    for (int w = 0; w < 8; w++)
      if (vw < 0 && s[w].mesi == c_mesi_i) vw = w;
    if (vw < 0)
      for (int w = 0; w < 8; w++)
        if (s[w].lru == 3'd7) vw = w;
    if (vw < 0) vw = 0;
    case (c.n)
      4'd0, 4'd1, 4'd2: begin
        e.hit = (hw >= 0);
        if (hw >= 0) begin
          if (c.n == 4'd1) begin
            if (s[hw].mesi == c_mesi_s) e.wr_op = c_bus_inval;
            e.set[hw].mesi = c_mesi_m;
          end
          e.set = touch(e.set, hw);
        end else begin
          if (s[vw].mesi == c_mesi_m) e.upd_op = c_bus_write;
          e.set[vw].tag = c.address.tag;
          if (c.n == 4'd1) begin
            e.set[vw].mesi = c_mesi_m;
            e.wr_op = c_bus_rwim;
          end else begin
            e.set[vw].mesi = (sn != 2'd0) ? c_mesi_s : c_mesi_e;
            e.wr_op = c_bus_read;
          end
          e.set = touch(e.set, vw);
        end
      end
      4'd3: begin
        e.hit = (hw >= 0);
        if (hw >= 0) begin
          e.rsp = (s[hw].mesi == c_mesi_m) ? c_rsp_hitm : c_rsp_hit;
          if (s[hw].mesi == c_mesi_m) e.wr_op = c_bus_write;
          e.set[hw].mesi = c_mesi_s;
        end
      end
      4'd4: e.hit = (hw >= 0);
      4'd8, 4'd9: begin
      end
      default: begin
        e.chk_set = 1'b0;
        e.noop = 1'b1;
      end
    endcase
    return e;
  endfunction

  task automatic run_cmd(input logic [3:0] n, input logic [11:0] tag, input logic [13:0] si,
                         input logic [1:0] sn, input bit hold, input string name);
    command_t c;
    exp_t     e;
    exp_t     g;
    int       idx;
    int       lat;
    c = '0;
    c.n = n;
    c.address.tag = tag;
    c.address.set_index = si;
    c.address.offset = 6'h15;
    idx = int'(si[3:0]);
    e = model(c, sn, ref_mem[idx]);
    sb.push_back(e);
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL %s ready_idle: got %b want 1", name, cmd_ready); end
    snoop_in = sn;
    cmd_in = c;
    cmd_valid = 1'b1;
    lat = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (!hold) cmd_valid = 1'b0;
        total++;
        if (e.noop ? (store_cmd.n !== 4'hf) : (store_cmd !== e.store)) begin
          bad++; $display("FAIL %s store_cmd_lookup: got %h want %h", name, store_cmd, e.store);
        end
        total++;
        if (cmd_ready !== 1'b0) begin bad++; $display("FAIL %s ready_busy: got %b want 0", name, cmd_ready); end
      end
      if (k == 2) begin
        cmd_valid = 1'b0;
        total++;
        if (bus_op !== e.upd_op) begin bad++; $display("FAIL %s bus_op_update: got %0d want %0d", name, bus_op, e.upd_op); end
      end
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
    total++;
    if (lat != 3) begin bad++; $display("FAIL %s done_latency: got %0d want 3", name, lat); end
    g = sb.pop_front();
    if (lat != 0) begin
      total++;
      if (hit !== g.hit) begin bad++; $display("FAIL %s hit: got %b want %b", name, hit, g.hit); end
      total++;
      if (bus_op !== g.wr_op) begin bad++; $display("FAIL %s bus_op_write: got %0d want %0d", name, bus_op, g.wr_op); end
      total++;
      if (snoop_rsp !== g.rsp) begin bad++; $display("FAIL %s snoop_rsp: got %0d want %0d", name, snoop_rsp, g.rsp); end
      total++;
      if (g.noop ? (store_cmd.n !== 4'hf) : (store_cmd !== g.store)) begin
        bad++; $display("FAIL %s store_cmd_write: got %h want %h", name, store_cmd, g.store);
      end
      if (g.chk_set) begin
        total++;
        if (cache_wr !== g.set) begin bad++; $display("FAIL %s cache_wr: got %h want %h", name, cache_wr, g.set); end
        ref_mem[idx] = g.set;
      end
      if (store_cmd.n != 4'hf) mem[idx] = cache_wr;
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || bus_op !== c_bus_none || snoop_rsp !== c_rsp_nohit || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL %s after_done: got done=%b bus=%0d rsp=%0d ready=%b want 0 0 0 1",
                      name, done, bus_op, snoop_rsp, cmd_ready);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL %s cmd_ready: got %b want 1", name, cmd_ready); end
    total++;
    if (store_cmd.n !== 4'hf) begin bad++; $display("FAIL %s store_n: got %h want f", name, store_cmd.n); end
    total++;
    if (cache_wr !== '0) begin bad++; $display("FAIL %s cache_wr: got %h want 0", name, cache_wr); end
    total++;
    if (bus_op !== 3'd0 || snoop_rsp !== 2'd0) begin
      bad++; $display("FAIL %s bus/rsp: got %0d/%0d want 0/0", name, bus_op, snoop_rsp);
    end
    total++;
    if (done !== 1'b0 || hit !== 1'b0) begin bad++; $display("FAIL %s done/hit: got %b/%b want 0/0", name, done, hit); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    check_reset_outputs("reset");
`ifdef CACHE_CTRL_STATS_EN
    total++;
    if ({stat_reads, stat_writes, stat_hits, stat_misses} !== '0) begin
      bad++; $display("FAIL reset stats: got %0d %0d %0d %0d want 0", stat_reads, stat_writes, stat_hits, stat_misses);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_release ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_read_miss();
    run_cmd(4'd0, 12'h123, 14'd5, 2'd0, 1'b0, "rd_miss");
    total++;
    if (mem[5][0].mesi !== c_mesi_e || mem[5][0].tag !== 12'h123 || mem[5][0].lru !== 3'd0) begin
      bad++; $display("FAIL rd_miss way0: got mesi=%0d tag=%h lru=%0d want 2 123 0",
                      mem[5][0].mesi, mem[5][0].tag, mem[5][0].lru);
    end
  endtask

  task automatic test_read_hit();
    run_cmd(4'd0, 12'h123, 14'd5, 2'd0, 1'b0, "rd_hit");
    total++;
    if (mem[5][0].mesi !== c_mesi_e || mem[5][1].lru !== 3'd1) begin
      bad++; $display("FAIL rd_hit set: got mesi0=%0d lru1=%0d want 2 1", mem[5][0].mesi, mem[5][1].lru);
    end
  endtask

  task automatic test_write_snoop();
    run_cmd(4'd1, 12'h123, 14'd5, 2'd0, 1'b0, "wr_hit_e");
    total++;
    if (mem[5][0].mesi !== c_mesi_m) begin bad++; $display("FAIL wr_hit_e mesi: got %0d want 3", mem[5][0].mesi); end
    run_cmd(4'd3, 12'h123, 14'd5, 2'd0, 1'b0, "snoop_rd_m");
    total++;
    if (mem[5][0].mesi !== c_mesi_s) begin bad++; $display("FAIL snoop_rd_m mesi: got %0d want 1", mem[5][0].mesi); end
  endtask

`ifdef CACHE_CTRL_STATS_EN
  task automatic test_stats();
    total++;
    if (stat_reads !== 32'd2 || stat_writes !== 32'd1 || stat_hits !== 32'd2 || stat_misses !== 32'd1) begin
      bad++; $display("FAIL stats: got r=%0d w=%0d h=%0d m=%0d want 2 1 2 1",
                      stat_reads, stat_writes, stat_hits, stat_misses);
    end
  endtask
`endif

  task automatic test_lru_evict();
    bit [7:0] seen;
    run_cmd(4'd1, 12'h200, 14'd7, 2'd0, 1'b0, "fill_wr0");
    for (int t = 1; t < 8; t++)
      run_cmd(4'd0, 12'h200 + 12'(t), 14'd7, 2'd0, 1'b0, "fill_rd");
    total++;
    if (mem[7][0].lru !== 3'd7) begin bad++; $display("FAIL fill way0 lru: got %0d want 7", mem[7][0].lru); end
    run_cmd(4'd0, 12'h208, 14'd7, 2'd1, 1'b0, "evict_m");
    total++;
    if (mem[7][0].tag !== 12'h208 || mem[7][0].mesi !== c_mesi_s) begin
      bad++; $display("FAIL evict_m way0: got tag=%h mesi=%0d want 208 1", mem[7][0].tag, mem[7][0].mesi);
    end
    run_cmd(4'd1, 12'h209, 14'd7, 2'd0, 1'b0, "evict_e_rwim");
    seen = '0;
    for (int w = 0; w < 8; w++) seen[mem[7][w].lru] = 1'b1;
    total++;
    if (seen !== 8'hff) begin bad++; $display("FAIL lru_perm: got %b want 11111111", seen); end
  endtask

  task automatic test_write_shared_hold();
    run_cmd(4'd1, 12'h123, 14'd5, 2'd0, 1'b1, "wr_hit_s_hold");
    total++;
    if (mem[5][0].mesi !== c_mesi_m) begin bad++; $display("FAIL wr_hit_s mesi: got %0d want 3", mem[5][0].mesi); end
  endtask

  task automatic test_misc_cmds();
    run_cmd(4'd5, 12'h123, 14'd5, 2'd0, 1'b0, "other_n");
    run_cmd(4'd8, 12'h123, 14'd5, 2'd0, 1'b0, "fwd_n8");
    run_cmd(4'd4, 12'h3ff, 14'd5, 2'd0, 1'b0, "snoop_wr");
    run_cmd(4'd2, 12'h123, 14'd5, 2'd1, 1'b0, "rd2_hit_m");
  endtask

  task automatic test_reset_mid();
    command_t c;
    c = '0;
    c.n = 4'd1;
    c.address.tag = 12'h0ab;
    c.address.set_index = 14'd9;
    @(negedge clk);
    snoop_in = 2'd0;
    cmd_in = c;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    total++;
    if (store_cmd !== c) begin bad++; $display("FAIL rst_mid store_cmd: got %h want %h", store_cmd, c); end
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL rst_mid after: got done=%b ready=%b want 0 1", done, cmd_ready);
    end
    run_cmd(4'd0, 12'h0ab, 14'd9, 2'd0, 1'b0, "post_rst_rd");
  endtask

  initial begin
    for (int i = 0; i < 16; i++)
      for (int w = 0; w < 8; w++) begin
        mem[i][w].mesi = c_mesi_i;
        mem[i][w].tag  = '0;
        mem[i][w].lru  = 3'(w);
        mem[i][w].data = 32'hd000_0000 | (i << 8) | w;
      end
    ref_mem = mem;
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write_snoop();
`ifdef CACHE_CTRL_STATS_EN
    test_stats();
`endif
    test_lru_evict();
    test_write_shared_hold();
    test_misc_cmds();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
